countdown_timer: RTL

Programmable countdown timer: the generating counterpart of the chronometer. The chronometer measures elapsed time in ms/us. This block is loaded with a duration in the same units, counts it down from the board clock, and flags expiry. It provides timeouts, delays and periodic events, optionally with auto-reload.

---
 rtl/timer_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 30 +++
 rtl/countdown_timer.sv | 107 ++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and helpers for the countdown timer and its unit prescaler.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int UNITS_MS = 0;
  localparam int UNITS_US = 1;

  // Board-clock cycles per timer unit.
  function automatic int tick_div(input longint freq_in, input int units);
    return (units == UNITS_US) ? int'(freq_in / 1000000) : int'(freq_in / 1000);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the board clock down to one tick per unit.
// The tick is combinational on the last count so the caller acts on the same cycle.
module tick_prescaler #(
  parameter int DIV = 12
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Programmable countdown timer in ms/us units with pause and optional auto-reload.
// Outputs are registered; a load takes effect on the edge that samples it.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int FREQ_IN          = 12_000_000,
  parameter int LIMIT_LOAD_TIMER = 1000,
  parameter int SELECT_UNITS     = UNITS_MS,
  parameter int W                = $clog2(LIMIT_LOAD_TIMER + 1)
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         loadTimer,
  input  logic [W-1:0] loadValue,
  input  logic         enableTimerCounter,
  input  logic         autoReload,
  output logic [W-1:0] remainingTimer,
  output logic         running,
  output logic         timerDone
);

  localparam int          TICK_DIV = tick_div(longint'(FREQ_IN), SELECT_UNITS);
  localparam logic [W-1:0] LIMIT   = W'(LIMIT_LOAD_TIMER);

  state_t       state_q, state_d;
  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] stored_q, stored_d;
  logic         done_q, done_d;
  logic         running_q, running_d;
  logic [W-1:0] clamped;
  logic         active;
  logic         tick;

  assign clamped = (loadValue > LIMIT) ? LIMIT : loadValue;
  assign active  = (state_q == ST_RUN) || (state_q == ST_PAUSE);

  // Counting only on enabled cycles keeps the pause delay exact: the resume
  // cycle out of PAUSE already counts, the cycle that drops enable does not.
  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .resetN (resetN),
    .clear  (loadTimer),
    .enable (active && enableTimerCounter),
    .tick   (tick)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    stored_d = stored_q;
    done_d   = 1'b0;
    if (loadTimer) begin
      stored_d = clamped;
      rem_d    = clamped;
      if (clamped == '0) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = enableTimerCounter ? ST_RUN : ST_PAUSE;
      end
    end else if (active) begin
      if (!enableTimerCounter) begin
        state_d = ST_PAUSE;
      end else begin
        state_d = ST_RUN;
        if (tick) begin
          if (rem_q > 1) begin
            rem_d = rem_q - 1'b1;
          end else begin
            done_d = 1'b1;
            if (autoReload) begin
              rem_d = stored_q;
            end else begin
              rem_d   = '0;
              state_d = ST_DONE;
            end
          end
        end
      end
    end
  end

  assign running_d = (state_d == ST_RUN);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      stored_q  <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      stored_q  <= stored_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign remainingTimer = rem_q;
  assign running        = running_q;
  assign timerDone      = done_q;

endmodule
